// File: rtl/mem_dbus_master.sv
`timescale 1ns/1ps
// MEM-stage data-bus master: serialises pipe a then pipe b accesses onto a single-outstanding
// req/gnt/rvalid bus and stalls the pipeline until done. Define DBUS_DUAL_ISSUE_EN to service pipe b.
module mem_dbus_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_a_ce,
    input  logic                  req_a_we,
    input  logic [ADDR_W-1:0]     req_a_addr,
    input  logic [DATA_W-1:0]     req_a_wdata,
    input  logic [DATA_W/8-1:0]   req_a_be,
    input  logic                  req_b_ce,
    input  logic                  req_b_we,
    input  logic [ADDR_W-1:0]     req_b_addr,
    input  logic [DATA_W-1:0]     req_b_wdata,
    input  logic [DATA_W/8-1:0]   req_b_be,
    input  logic                  flush,
    input  logic                  pipe_hold,
    output logic                  stall_req,
    output logic [DATA_W-1:0]     rdata_a,
    output logic [DATA_W-1:0]     rdata_b,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_be,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [DATA_W-1:0]     bus_rdata
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ_A  = 3'd1;
    localparam logic [2:0] ST_WAIT_A = 3'd2;
    localparam logic [2:0] ST_REQ_B  = 3'd3;
    localparam logic [2:0] ST_WAIT_B = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_DRAIN  = 3'd6;

    logic [2:0]          state_reg;
    logic [2:0]          state_next;
    logic                b_ce;
    logic                any_ce;
    logic                load_a;
    logic                load_b;
    logic                drop_req;
    logic                cap_a;
    logic                cap_b;

    logic                bus_req_reg;
    logic                bus_we_reg;
    logic [ADDR_W-1:0]   bus_addr_reg;
    logic [DATA_W-1:0]   bus_wdata_reg;
    logic [DATA_W/8-1:0] bus_be_reg;
    logic [DATA_W-1:0]   rdata_a_reg;

`ifdef DBUS_DUAL_ISSUE_EN
    assign b_ce = req_b_ce;
`else
    assign b_ce = 1'b0;
`endif
    assign any_ce = req_a_ce | b_ce;

    always_comb begin
        state_next = state_reg;
        load_a     = 1'b0;
        load_b     = 1'b0;
        drop_req   = 1'b0;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!flush && req_a_ce) begin
                    state_next = ST_REQ_A;
                    load_a     = 1'b1;
                end else if (!flush && b_ce) begin
                    state_next = ST_REQ_B;
                    load_b     = 1'b1;
                end
            end
            ST_REQ_A, ST_REQ_B: begin
                // A grant in the flush cycle means a response is still owed: drain it.
                if (flush) begin
                    drop_req   = 1'b1;
                    state_next = bus_gnt ? ST_DRAIN : ST_IDLE;
                end else if (bus_gnt) begin
                    drop_req   = 1'b1;
                    state_next = (state_reg == ST_REQ_A) ? ST_WAIT_A : ST_WAIT_B;
                end
            end
            ST_WAIT_A: begin
                if (bus_rvalid) begin
                    if (flush) begin
                        state_next = ST_IDLE;
                    end else begin
                        cap_a = ~bus_we_reg;
                        if (b_ce) begin
                            state_next = ST_REQ_B;
                            load_b     = 1'b1;
                        end else begin
                            state_next = ST_DONE;
                        end
                    end
                end else if (flush) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_WAIT_B: begin
                if (bus_rvalid) begin
                    if (flush) begin
                        state_next = ST_IDLE;
                    end else begin
                        cap_b      = ~bus_we_reg;
                        state_next = ST_DONE;
                    end
                end else if (flush) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (flush || !pipe_hold) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (bus_rvalid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_req = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DRAIN:                        stall_req = any_ce;
            ST_REQ_A, ST_WAIT_A, ST_REQ_B, ST_WAIT_B: stall_req = 1'b1;
            default:                                  stall_req = 1'b0;
        endcase
        if (!rst_n) begin
            stall_req = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            bus_be_reg    <= '0;
            rdata_a_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (load_a) begin
                bus_req_reg   <= 1'b1;
                bus_we_reg    <= req_a_we;
                bus_addr_reg  <= req_a_addr;
                bus_wdata_reg <= req_a_wdata;
                bus_be_reg    <= req_a_be;
            end else if (load_b) begin
                bus_req_reg   <= 1'b1;
                bus_we_reg    <= req_b_we;
                bus_addr_reg  <= req_b_addr;
                bus_wdata_reg <= req_b_wdata;
                bus_be_reg    <= req_b_be;
            end else if (drop_req) begin
                bus_req_reg   <= 1'b0;
            end
            if (cap_a) begin
                rdata_a_reg <= bus_rdata;
            end
        end
    end

`ifdef DBUS_DUAL_ISSUE_EN
    logic [DATA_W-1:0] rdata_b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_b_reg <= '0;
        end else if (cap_b) begin
            rdata_b_reg <= bus_rdata;
        end
    end
    assign rdata_b = rdata_b_reg;
`else
    logic unused_pipe_b;
    assign unused_pipe_b = req_b_ce | cap_b;
    assign rdata_b       = '0;
`endif

    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign bus_be    = bus_be_reg;
    assign rdata_a   = rdata_a_reg;

endmodule

// File: tb/tb_mem_dbus_master.sv
`timescale 1ns/1ps
// Bench for mem_dbus_master: memory-backed bus responder, reference memory model and
// queue scoreboards for bus transactions and per-instruction load results.
module tb_mem_dbus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a_ce, req_a_we, req_b_ce, req_b_we;
    logic [31:0] req_a_addr, req_a_wdata, req_b_addr, req_b_wdata;
    logic [3:0]  req_a_be, req_b_be;
    logic        flush, pipe_hold, stall_req;
    logic [31:0] rdata_a, rdata_b;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

`ifdef DBUS_DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_dbus_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a_ce(req_a_ce), .req_a_we(req_a_we), .req_a_addr(req_a_addr),
        .req_a_wdata(req_a_wdata), .req_a_be(req_a_be),
        .req_b_ce(req_b_ce), .req_b_we(req_b_we), .req_b_addr(req_b_addr),
        .req_b_wdata(req_b_wdata), .req_b_be(req_b_be),
        .flush(flush), .pipe_hold(pipe_hold), .stall_req(stall_req),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    typedef struct packed {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } preq_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_txn_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } res_t;

    int          checks = 0;
    int          errors = 0;
    bus_txn_t    exp_bus_q[$];
    res_t        exp_res_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] prev_a = 0, prev_b = 0;
    logic [31:0] committed_a = 0, committed_b = 0;
    bit          live = 1'b0;
    int          gnt_fix = 0, rv_fix = 0;
    bit          rnd_dly = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = be[i] ? nw[i*8 +: 8] : old[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] addr);
        return ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] addr);
        return slv_mem.exists(addr) ? slv_mem[addr] : dflt(addr);
    endfunction

    function automatic int pick(input int f);
        return rnd_dly ? int'($urandom_range(0, 3)) : f;
    endfunction

    function automatic preq_t mk(input logic ce, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        preq_t r;
        r.ce = ce; r.we = we; r.addr = addr; r.wdata = wdata; r.be = be;
        return r;
    endfunction

    function automatic bus_txn_t to_txn(input preq_t p);
        bus_txn_t t;
        t.we = p.we; t.addr = p.addr; t.wdata = p.wdata; t.be = p.be;
        return t;
    endfunction

    task automatic apply(input preq_t a, input preq_t b);
        req_a_ce = a.ce; req_a_we = a.we; req_a_addr = a.addr; req_a_wdata = a.wdata; req_a_be = a.be;
        req_b_ce = b.ce; req_b_we = b.we; req_b_addr = b.addr; req_b_wdata = b.wdata; req_b_be = b.be;
    endtask

    // Reference: a then b, in program order, against a flat word memory.
    task automatic model_inst(input preq_t a, input preq_t b);
        if (a.ce) begin
            exp_bus_q.push_back(to_txn(a));
            if (a.we) ref_mem[a.addr] = merge(ref_rd(a.addr), a.wdata, a.be);
            else      prev_a = ref_rd(a.addr);
        end
        if (DUAL && b.ce) begin
            exp_bus_q.push_back(to_txn(b));
            if (b.we) ref_mem[b.addr] = merge(ref_rd(b.addr), b.wdata, b.be);
            else      prev_b = ref_rd(b.addr);
        end
        exp_res_q.push_back({prev_a, prev_b});
    endtask

    // Returns at the negedge where stall_req is first low; counts stalled cycles.
    task automatic wait_done(input bit chk_a, output int sc);
        sc = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!stall_req) return;
            sc++;
            chk("stall_rdata_b_stable", rdata_b, committed_b);
            if (chk_a) chk("stall_rdata_a_stable", rdata_a, committed_a);
        end
        checks++; errors++;
        $display("FAIL stall_timeout: stall_req still 1 after 300 cycles, required 0");
    endtask

    task automatic run_inst(input preq_t a, input preq_t b, input int hold, output int sc);
        apply(a, b);
        model_inst(a, b);
        pipe_hold = (hold > 0);
        live = 1'b1;
        wait_done(!(DUAL && a.ce && b.ce), sc);
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            pipe_hold = 1'b0;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_handshake();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus_req && bus_gnt) return;
        end
        checks++; errors++;
        $display("FAIL handshake_timeout: no bus grant within 100 cycles, required one");
    endtask

    // Bus responder backed by its own memory; grant/response delays configurable.
    initial begin
        int gwait;
        int rwait;
        bit pending;
        logic [31:0] rsp;
        gwait = -1; rwait = 0; pending = 1'b0; rsp = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
            if (!rst_n) begin
                gwait = -1; pending = 1'b0;
            end else if (pending) begin
                if (rwait == 0) begin
                    bus_rvalid = 1'b1; bus_rdata = rsp; pending = 1'b0;
                end else begin
                    rwait--;
                end
            end else if (bus_req) begin
                if (gwait < 0) gwait = pick(gnt_fix);
                if (gwait == 0) begin
                    bus_gnt = 1'b1; gwait = -1; pending = 1'b1; rwait = pick(rv_fix);
                    if (bus_we) begin
                        slv_mem[bus_addr] = merge(slv_rd(bus_addr), bus_wdata, bus_be);
                        rsp = $urandom;
                    end else begin
                        rsp = slv_rd(bus_addr);
                    end
                end else begin
                    gwait--;
                end
            end else begin
                gwait = -1;
            end
        end
    end

    // Monitor: bus handshakes and instruction completions against the queues.
    always @(negedge clk) begin
        bus_txn_t e;
        res_t     r;
        if (rst_n) begin
            if (bus_req && bus_gnt) begin
                if (exp_bus_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected: got request addr %h we %b, expected no request", bus_addr, bus_we);
                end else begin
                    e = exp_bus_q.pop_front();
                    chk("bus_we", {31'd0, bus_we}, {31'd0, e.we});
                    chk("bus_addr", bus_addr, e.addr);
                    chk("bus_wdata", bus_wdata, e.wdata);
                    chk("bus_be", {28'd0, bus_be}, {28'd0, e.be});
                end
            end
            if (live && !stall_req) begin
                if (exp_res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL result_unexpected: got completion, expected none queued");
                    live = 1'b0;
                end else if (pipe_hold) begin
                    chk("hold_bus_req", {31'd0, bus_req}, 32'd0);
                    chk("hold_rdata_a", rdata_a, exp_res_q[0].a);
                    chk("hold_rdata_b", rdata_b, exp_res_q[0].b);
                end else begin
                    r = exp_res_q.pop_front();
                    chk("rdata_a", rdata_a, r.a);
                    chk("rdata_b", rdata_b, r.b);
                    committed_a = r.a;
                    committed_b = r.b;
                    live = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded 1 ms, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        preq_t none;
        preq_t a;
        preq_t b;
        int    sc;
        int    hold;
        none = mk(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        rst_n = 1'b0; flush = 1'b0; pipe_hold = 1'b0;
        apply(none, none);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_stall_req", {31'd0, stall_req}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst_rdata_a", rdata_a, 32'd0);
        chk("rst_rdata_b", rdata_b, 32'd0);
        @(posedge clk); #1;

        // Minimum-latency single load.
        slv_mem[32'h1000] = 32'hDEAD_BEEF;
        ref_mem[32'h1000] = 32'hDEAD_BEEF;
        run_inst(mk(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF), none, 0, sc);
        chk("single_load_stall_cycles", sc, 32'd3);

        // Reset in WAIT_A with the response still outstanding.
        rv_fix = 3;
        a = mk(1'b1, 1'b0, 32'h1020, 32'h0, 4'hF);
        apply(a, none);
        exp_bus_q.push_back(to_txn(a));
        wait_handshake();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_stall_req", {31'd0, stall_req}, 32'd0);
        chk("midrst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("midrst_bus_addr", bus_addr, 32'd0);
        chk("midrst_bus_be", {28'd0, bus_be}, 32'd0);
        chk("midrst_rdata_a", rdata_a, 32'd0);
        chk("midrst_rdata_b", rdata_b, 32'd0);
        prev_a = 0; prev_b = 0; committed_a = 0; committed_b = 0;
        apply(none, none);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        rv_fix = 0;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_bus_req", {31'd0, bus_req}, 32'd0);
            chk("postrst_stall_req", {31'd0, stall_req}, 32'd0);
        end
        @(posedge clk); #1;

        // Store a + load b with two grant wait states each.
        gnt_fix = 2;
        run_inst(mk(1'b1, 1'b1, 32'h2000, 32'h1122_3344, 4'hF),
                 mk(1'b1, 1'b0, 32'h2004, 32'h0, 4'hF), 0, sc);
        chk("dual_gnt2_stall_cycles", sc, DUAL ? 32'd9 : 32'd5);
        gnt_fix = 0;
        run_inst(mk(1'b1, 1'b0, 32'h2000, 32'h0, 4'hF),
                 mk(1'b1, 1'b0, 32'h2008, 32'h0, 4'hF), 0, sc);
        chk("dual_min_stall_cycles", sc, DUAL ? 32'd5 : 32'd3);

        // pipe_hold for four cycles in DONE.
        run_inst(mk(1'b1, 1'b0, 32'h1008, 32'h0, 4'hF), none, 4, sc);

        // Pipe b alone.
        run_inst(none, mk(1'b1, 1'b0, 32'h100C, 32'h0, 4'hF), 0, sc);
        chk("b_only_stall_cycles", sc, DUAL ? 32'd3 : 32'd0);

        // Flush in WAIT_A, response two cycles later, new load presented during drain.
        rv_fix = 2;
        a = mk(1'b1, 1'b0, 32'h1010, 32'h0, 4'hF);
        apply(a, none);
        exp_bus_q.push_back(to_txn(a));
        wait_handshake();
        rv_fix = 0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        run_inst(mk(1'b1, 1'b0, 32'h1014, 32'h0, 4'hF), none, 0, sc);
        chk("flush_drain_stall_cycles", sc, 32'd5);

        // Randomised traffic over a small address window to force RAW hazards.
        rnd_dly = 1'b1;
        for (int i = 0; i < 150; i++) begin
            a = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   32'h3000 + ($urandom_range(0, 7) << 2), $urandom, 4'($urandom_range(1, 15)));
            b = mk($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                   32'h3000 + ($urandom_range(0, 7) << 2), $urandom, 4'($urandom_range(1, 15)));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_inst(a, b, hold, sc);
        end
        apply(none, none);
        repeat (5) @(posedge clk);
        #1;
        chk("bus_queue_drained", exp_bus_q.size(), 32'd0);
        chk("result_queue_drained", exp_res_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_dbus_master.md
# mem_dbus_master

Memory-stage data-bus master sitting directly downstream of the EX/MEM pipeline register. It consumes the registered memory requests of both issue pipes (a, b), serialises them onto a single-outstanding request/grant/response data bus, holds the pipeline with `stall_req` until every enabled access has completed, and presents load data to the MEM stage. It is the responder end of the `memory_req` fields carried in `PipelineReq_t`.

## Interface
Parameters:
- `ADDR_W`, 32, bus/request address width
- `DATA_W`, 32, data width; byte enables are `DATA_W/8` bits

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_a_ce`, `req_a_we`  in  1 each  pipe-a access enable / write
- `req_a_addr`  in  ADDR_W  pipe-a address (word-aligned, checked upstream)
- `req_a_wdata`  in  DATA_W  pipe-a store data
- `req_a_be`  in  DATA_W/8  pipe-a byte enables
- `req_b_*`  in  same as pipe a  pipe-b request
- `flush`  in  1  kill current MEM-stage instructions
- `pipe_hold`  in  1  later stage stalling MEM; results must be held
- `stall_req`  out  1  MEM stage not finished; pipeline control stalls EX and earlier
- `rdata_a`, `rdata_b`  out  DATA_W  captured load data per pipe
- `bus_req`  out  1  request valid; held until `bus_gnt`
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`  out  request payload
- `bus_gnt`  in  1  request accepted this cycle
- `bus_rvalid`  in  1  response (read data or write ack) this cycle
- `bus_rdata`  in  DATA_W  read data, valid with `bus_rvalid`

## Operation
- States: IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, DONE, DRAIN.
- IDLE: `req_a_ce` -> REQ_A; else `req_b_ce` -> REQ_B; else stay. Payload latched into bus regs on transition.
- REQ_x: `bus_req`=1, payload stable; `bus_gnt` -> WAIT_x.
- WAIT_A: `bus_rvalid` -> capture `rdata_a` (reads only; writes leave it unchanged); then REQ_B if `req_b_ce` else DONE.
- WAIT_B: `bus_rvalid` -> capture `rdata_b`; -> DONE.
- DONE: `stall_req`=0; stay while `pipe_hold`; else IDLE.
- `stall_req` = (IDLE and any ce) or state in {REQ_A, WAIT_A, REQ_B, WAIT_B} or (DRAIN and any ce).
- Exactly one outstanding transaction; pipe a always precedes pipe b.
- `flush`: in IDLE/DONE/REQ_x before grant -> IDLE, `bus_req` dropped same edge. In WAIT_x (or REQ_x with `bus_gnt` that cycle) -> DRAIN; response discarded on arrival, then IDLE. Flush never corrupts `rdata_*` with drained data.
- Reset: state IDLE; `bus_req`, `bus_we` 0; `bus_addr`, `bus_wdata`, `bus_be`, `rdata_a`, `rdata_b` all zero; `stall_req` 0. Reset mid-transaction abandons it; the bus is also reset.

## Timing
- Bus outputs registered; `stall_req` combinational from state and current inputs.
- Minimum single access: c0 IDLE sees ce, stall_req=1; c1 REQ_A, gnt; c2 WAIT_A, rvalid; c3 DONE, stall_req=0, rdata valid. Latency 3 cycles + bus wait states.
- Dual access minimum: 5 cycles (DONE at c5).
- `bus_rvalid` never occurs in the same cycle as its `bus_gnt`; `bus_rvalid` outside WAIT_x/DRAIN is ignored.
- `rdata_*` stable from DONE entry until the next capture.
- `flush` and `bus_rvalid` same cycle in WAIT_x: response discarded, -> IDLE directly.

## Configuration
- `DBUS_DUAL_ISSUE_EN` defined: pipe b serviced as above.
- Undefined: `req_b_*` ignored (treated as ce=0), REQ_B/WAIT_B unreachable, `rdata_b` constant zero; WAIT_A always -> DONE.

## Test plan
- Reset asserted mid-WAIT_A -> all outputs zero immediately, IDLE after `rst_n` rises, no `bus_req`.
- Load a addr 0x0000_1000, gnt c1, rvalid c2 data 0xDEAD_BEEF -> stall_req high c0-c2, low c3, `rdata_a`=0xDEADBEEF.
- Store a + load b, gnt delayed 2 cycles each -> bus order a then b, `bus_req` held through wait states, `rdata_b` captured, `rdata_a` unchanged.
- Flush in WAIT_A, rvalid 2 cycles later, new load ce next cycle -> DRAIN, stall_req high, old data discarded, new load issued only after drain.
- `pipe_hold` high 4 cycles in DONE -> stall_req low, no new bus_req, `rdata_*` stable.
- Build without `DBUS_DUAL_ISSUE_EN`, req_b_ce=1 only -> no bus activity, stall_req 0, `rdata_b`=0.
